// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: shared state type, synchroniser depth limits and counter width helper
package gpio_cond_pkg;
  typedef enum logic {ST_STABLE, ST_COUNT} state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if: raw pad inputs, debounce qualifier and conditioned outputs
interface gpio_in_conditioner_if #(parameter int IO_NUM = 4);
  logic [IO_NUM-1:0] PAD_IN;
  logic TICK;
  logic [IO_NUM-1:0] GPIO_IN_CLEAN;
  logic [IO_NUM-1:0] CHANGING;
  logic [IO_NUM-1:0] RISE_PULSE;
  logic [IO_NUM-1:0] FALL_PULSE;
  modport master (output PAD_IN, TICK, input GPIO_IN_CLEAN, CHANGING, RISE_PULSE, FALL_PULSE);
  modport slave (input PAD_IN, TICK, output GPIO_IN_CLEAN, CHANGING, RISE_PULSE, FALL_PULSE);
endinterface

// File: rtl/gpio_in_conditioner_bit.sv
// gpio_in_conditioner_bit: one bit's synchroniser, debounce FSM and edge pulses
// Pulse flops exist only when GPIO_IN_CONDITIONER_PULSE_EN is defined.
module gpio_in_conditioner_bit
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL = 1'b0
) (
  input logic PCLK,
  input logic PRESETN,
  input logic pad,
  input logic tick,
  output logic clean,
  output logic changing,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sr;
  logic sync, diff, done, clean_nxt;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  assign sync = sr[SYNC_STAGES-1];
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      sr <= {SYNC_STAGES{RESET_VAL}};
      state <= ST_STABLE;
      cnt <= '0;
      clean <= RESET_VAL;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], pad};
      state <= state_nxt;
      cnt <= cnt_nxt;
      clean <= clean_nxt;
    end
  // A return to the clean level aborts the count regardless of tick.
  always_comb begin
    diff = sync != clean;
    done = tick && diff && cnt == LAST;
    state_nxt = (!diff || done) ? ST_STABLE : tick ? ST_COUNT : state;
    cnt_nxt = (!diff || done) ? '0 : tick ? cnt + CW'(1) : cnt;
    clean_nxt = done ? sync : clean;
  end
  always_comb changing = state == ST_COUNT;
`ifdef GPIO_IN_CONDITIONER_PULSE_EN
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= done && sync;
      fall <= done && !sync;
    end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-bit synchronise and debounce of pad inputs feeding GPIO_IN
// Rise/fall pulses are built only with GPIO_IN_CONDITIONER_PULSE_EN defined.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int IO_NUM = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [IO_NUM-1:0] RESET_VAL = '0
) (
  input logic PCLK,
  input logic PRESETN,
  gpio_in_conditioner_if.slave bus
);
  logic [IO_NUM-1:0] clean, changing, rise, fall;
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("gpio_in_conditioner: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("gpio_in_conditioner: DEBOUNCE_CYCLES=%0d outside 1..65535", DEBOUNCE_CYCLES);
  end
  for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
    gpio_in_conditioner_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL(RESET_VAL[i])
    ) u_bit (
      .PCLK(PCLK),
      .PRESETN(PRESETN),
      .pad(bus.PAD_IN[i]),
      .tick(bus.TICK),
      .clean(clean[i]),
      .changing(changing[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  assign bus.GPIO_IN_CLEAN = clean;
  assign bus.CHANGING = changing;
  assign bus.RISE_PULSE = rise;
  assign bus.FALL_PULSE = fall;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed and randomized checks of gpio_in_conditioner against a run-length model
module tb_gpio_in_conditioner;
  localparam int N = 4;
  localparam int SYNC = 2;
  localparam int DEB = 16;
  localparam logic [N-1:0] RV = '0;
`ifdef GPIO_IN_CONDITIONER_PULSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic PCLK = 1'b0;
  logic PRESETN = 1'b0;
  int checks = 0;
  int failures = 0;
  gpio_in_conditioner_if #(.IO_NUM(N)) bus ();
  gpio_in_conditioner #(
    .IO_NUM(N),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_VAL(RV)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;

  task automatic checkv(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Model: pad delayed SYNC edges; clean follows once it has differed for DEB consecutive qualified ticks.
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_clean = RV;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  int run [N];
  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int j = 0; j < SYNC; j++) m_pipe[j] = RV;
      m_clean = RV;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      logic [N-1:0] s;
      s = m_pipe[SYNC-1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (s[i] == m_clean[i]) run[i] = 0;
        else if (bus.TICK) begin
          run[i] = run[i] + 1;
          if (run[i] == DEB) begin
            run[i] = 0;
            m_clean[i] = s[i];
            m_rise[i] = PE && s[i];
            m_fall[i] = PE && !s[i];
          end
        end
      end
      for (int j = SYNC - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
      m_pipe[0] = bus.PAD_IN;
    end
  end

  always @(negedge PCLK) begin
    logic [N-1:0] m_chg;
    for (int i = 0; i < N; i++) m_chg[i] = run[i] != 0;
    checkv("cyc_clean", bus.GPIO_IN_CLEAN, m_clean);
    checkv("cyc_changing", bus.CHANGING, m_chg);
    checkv("cyc_rise", bus.RISE_PULSE, m_rise);
    checkv("cyc_fall", bus.FALL_PULSE, m_fall);
  end

  initial begin
    logic [N-1:0] old_v, exp_v, seen;
    int hi, idx;
    bit gated;
    bus.PAD_IN = 4'b1010;
    bus.TICK = 1'b1;
    repeat (3) step();
    checkv("t1_reset_clean", bus.GPIO_IN_CLEAN, 4'b0000);
    checkv("t1_reset_chg", bus.CHANGING, 4'b0000);
    checkv("t1_reset_pulse", bus.RISE_PULSE | bus.FALL_PULSE, 4'b0000);
    PRESETN = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) checkv("t1_no_pulse_after_release", bus.RISE_PULSE, 4'b0000);
      if (k == 17) checkv("t1_clean_edge17", bus.GPIO_IN_CLEAN, 4'b0000);
      if (k == 18) begin
        checkv("t1_clean_edge18", bus.GPIO_IN_CLEAN, 4'b1010);
        checkv("t1_model_edge18", m_clean, 4'b1010);
        checkv("t1_rise_edge18", bus.RISE_PULSE, PE ? 4'b1010 : 4'b0000);
      end
      if (k == 19) checkv("t1_rise_edge19", bus.RISE_PULSE, 4'b0000);
    end
    repeat (4) step();
    hi = 0;
    seen = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) bus.PAD_IN = 4'b1011;
      if (k == 11) bus.PAD_IN = 4'b1010;
      step();
      if (bus.CHANGING[0]) hi++;
      seen |= bus.RISE_PULSE | bus.FALL_PULSE;
    end
    checki("t2_changing_cycles", hi, 10);
    checkv("t2_clean", bus.GPIO_IN_CLEAN, 4'b1010);
    checkv("t2_no_pulse", seen, 4'b0000);
    bus.PAD_IN = 4'b1110;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 17) checkv("t3_rise_clean17", bus.GPIO_IN_CLEAN, 4'b1010);
      if (k == 18) begin
        checkv("t3_rise_clean18", bus.GPIO_IN_CLEAN, 4'b1110);
        checkv("t3_rise_pulse18", bus.RISE_PULSE, PE ? 4'b0100 : 4'b0000);
      end
      if (k == 19) checkv("t3_rise_pulse19", bus.RISE_PULSE, 4'b0000);
    end
    bus.PAD_IN = 4'b1010;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 17) checkv("t3_fall_clean17", bus.GPIO_IN_CLEAN, 4'b1110);
      if (k == 18) begin
        checkv("t3_fall_clean18", bus.GPIO_IN_CLEAN, 4'b1010);
        checkv("t3_fall_pulse18", bus.FALL_PULSE, PE ? 4'b0100 : 4'b0000);
      end
      if (k == 19) checkv("t3_fall_pulse19", bus.FALL_PULSE, 4'b0000);
    end
    bus.PAD_IN = 4'b1000;
    for (int k = 1; k <= 64; k++) begin
      bus.TICK = (k % 4 == 0);
      step();
      if (k == 63) checkv("t4_gated_clean63", bus.GPIO_IN_CLEAN, 4'b1010);
      if (k == 64) checkv("t4_gated_clean64", bus.GPIO_IN_CLEAN, 4'b1000);
    end
    bus.PAD_IN = 4'b1010;
    for (int k = 1; k <= 80; k++) begin
      if (k == 41) bus.PAD_IN = 4'b1000;
      bus.TICK = (k % 4 == 0);
      step();
    end
    checkv("t4_gated_glitch", bus.GPIO_IN_CLEAN, 4'b1000);
    bus.TICK = 1'b1;
    repeat (20) step();
    bus.PAD_IN = 4'b0000;
    repeat (10) step();
    checkv("t5_counting", bus.CHANGING, 4'b1000);
    PRESETN = 1'b0;
    #1;
    checkv("t5_reset_chg", bus.CHANGING, 4'b0000);
    checkv("t5_reset_clean", bus.GPIO_IN_CLEAN, RV);
    checkv("t5_reset_pulse", bus.RISE_PULSE | bus.FALL_PULSE, 4'b0000);
    repeat (3) step();
    bus.PAD_IN = 4'b1000;
    PRESETN = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 17) checkv("t5_redebounce17", bus.GPIO_IN_CLEAN, 4'b0000);
      if (k == 18) begin
        checkv("t5_redebounce18", bus.GPIO_IN_CLEAN, 4'b1000);
        checkv("t5_rise18", bus.RISE_PULSE, PE ? 4'b1000 : 4'b0000);
      end
    end
    repeat (3) step();
    old_v = bus.PAD_IN;
    for (int k = 0; k <= 30; k++) begin
      for (int i = 0; i < N; i++) if (k == 3 * i) bus.PAD_IN[i] = ~bus.PAD_IN[i];
      step();
      for (int i = 0; i < N; i++) exp_v[i] = (k + 1 >= 3 * i + 18) ? ~old_v[i] : old_v[i];
      checkv("t6_stagger", bus.GPIO_IN_CLEAN, exp_v);
    end
    gated = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) gated = 1'($urandom_range(0, 1));
      bus.TICK = gated ? ($urandom_range(0, 2) == 0) : 1'b1;
      if ($urandom_range(0, 24) == 0) bus.PAD_IN = N'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        bus.PAD_IN[idx] = ~bus.PAD_IN[idx];
      end
      PRESETN = ($urandom_range(0, 999) != 0);
      step();
    end
    PRESETN = 1'b1;
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input conditioning stage directly upstream of the 4-bit APB GPIO controller. Raw, asynchronous pad inputs are synchronised into the PCLK domain and debounced per bit. The stable result drives the controller's GPIO_IN bus, so its edge/level interrupt logic only sees clean transitions. Optional single-cycle rise/fall pulses are provided for logic that needs events without going through APB.

## Interface
Parameters:
- IO_NUM, 4, number of conditioned bits; matches the controller's IO_NUM.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive qualified ticks a new level must persist; legal range 1..65535.
- RESET_VAL, 0, IO_NUM-bit reset value of the clean outputs and synchroniser flops.

Ports:
- PCLK  in  1  clock, shared with the APB GPIO controller.
- PRESETN  in  1  reset; one clock, asynchronous active-low reset.
- PAD_IN  in  IO_NUM  raw pad levels, asynchronous to PCLK.
- TICK  in  1  debounce qualifier; counters advance only when high. Tie to 1 for per-cycle debounce.
- GPIO_IN_CLEAN  out  IO_NUM  debounced level; connects to the controller's GPIO_IN.
- CHANGING  out  IO_NUM  high while the bit's debounce counter is non-zero.
- RISE_PULSE  out  IO_NUM  one-cycle pulse on a clean 0→1 transition.
- FALL_PULSE  out  IO_NUM  one-cycle pulse on a clean 1→0 transition.

## Operation
Each bit is processed independently.
- **Synchroniser:** a SYNC_STAGES flop chain. Its last stage is sync[i].
- **State machine**, two states per bit:
  - **STABLE**, entered on reset with cnt = 0. When TICK is high and sync ≠ clean, cnt becomes 1 and the bit moves to COUNT. If DEBOUNCE_CYCLES = 1, clean updates immediately and the bit stays in STABLE.
  - **COUNT:**
    - sync == clean, on any edge regardless of TICK: cnt becomes 0 and the bit returns to STABLE. The glitch is rejected and clean is unchanged.
    - TICK high, sync ≠ clean, cnt < DEBOUNCE_CYCLES−1: cnt increments.
    - TICK high, sync ≠ clean, cnt == DEBOUNCE_CYCLES−1: clean takes sync, cnt becomes 0, the bit returns to STABLE, and the matching pulse flop is set.
    - TICK low, sync ≠ clean: hold.
- **Counter width:** clog2(DEBOUNCE_CYCLES). The counter never wraps, because reaching DEBOUNCE_CYCLES−1 forces the update.
- **CHANGING[i]** = (cnt ≠ 0).
- **Reset mid-count:** aborts the count. Clean returns to RESET_VAL and no pulse is generated.

## Timing
- **Latency:** with TICK = 1, a pad change that meets setup before edge 0 appears on GPIO_IN_CLEAN after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults this is 18 cycles.
- **Pulses:** registered on the same edge as the clean update, high for exactly one cycle. They are aligned with the first cycle of the new GPIO_IN_CLEAN value.
- **Glitch rejection:** a pad pulse shorter than DEBOUNCE_CYCLES qualified ticks, measured at the synchroniser output, never reaches GPIO_IN_CLEAN.
- **Reset values:**
  - GPIO_IN_CLEAN = RESET_VAL.
  - CHANGING = 0.
  - RISE_PULSE = 0, FALL_PULSE = 0.
  - All synchroniser flops = RESET_VAL.
- **Deassertion:** no pulse is emitted in the first cycle after reset release, even if PAD_IN ≠ RESET_VAL. That difference is debounced normally.

## Configuration
- Macro: GPIO_IN_CONDITIONER_PULSE_EN.
- **Defined:** pulse flops and logic are built as described above.
- **Undefined:** RISE_PULSE and FALL_PULSE remain as ports but are driven constant 0, and no pulse flops are synthesised. Debounce and CHANGING are unaffected.

## Structure
- **Shared package gpio_cond_pkg holds:**
  - the per-bit state enum (ST_STABLE, ST_COUNT);
  - the synchroniser depth limits (SYNC_MIN = 2, SYNC_MAX = 4);
  - a count-width function (clog2, minimum 1).
- **Sub-module gpio_in_conditioner_bit:** holds one bit's synchroniser, counter, state and pulse flops. The top level instantiates it IO_NUM times in a generate loop and checks parameter legality at elaboration.

## Test plan
1. **Reset and idle:** assert PRESETN = 0 with PAD_IN = 4'b1010, then release. Required: GPIO_IN_CLEAN = 0 during reset, no pulses, and after 18 cycles GPIO_IN_CLEAN = 4'b1010. With PULSE_EN defined, RISE_PULSE = 4'b1010 for exactly one cycle.
2. **Glitch rejection:** PAD_IN[0] goes high for 10 cycles with TICK = 1 and defaults. Required: GPIO_IN_CLEAN[0] stays 0, CHANGING[0] is high for 10 cycles then returns to 0, and no pulse occurs.
3. **Exact threshold:** PAD_IN[2] goes 0→1 and holds. Required: GPIO_IN_CLEAN[2] = 1 exactly at edge 18, and RISE_PULSE[2] is high only in that cycle. The same for 1→0 on FALL_PULSE[2].
4. **TICK gating:** with TICK high every 4th cycle, a PAD_IN[1] change must propagate after 2 + (16 qualified ticks) cycles. A 40-cycle pulse under this gating must be rejected.
5. **Reset mid-count:** start a transition on PAD_IN[3] and assert PRESETN at count 8. Required: CHANGING = 0, clean = RESET_VAL, no pulse. After release the input re-debounces from 0.
6. **Independence and macro off:** toggle all four bits on staggered cycles. Required: each bit updates at its own edge 18, with no cross-bit interference. Rebuilt without GPIO_IN_CONDITIONER_PULSE_EN, both pulse outputs stay 0.
